// File: rtl/ls_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : ls_queue_unit
// Brief    : In-order load/store queue. It computes addresses when an op is
//            enqueued and drains one op at a time to the data cache using the
//            rd/wr/waitrequest protocol. Each op retires through a one-cycle
//            ROB writeback.
// Options  : LSQ_MISALIGN_EXC_EN - misaligned half/word ops retire with
//            rob_exc and never touch the cache.
// Revision : 1.0 - initial release
// ============================================================================
module ls_queue_unit #(
  parameter int ROB_DEPTHLOG2 = 4,
  parameter int QDEPTH_LOG2   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_is_load,
  input  logic                     in_is_store,
  input  logic [1:0]               in_ls_op,
  input  logic                     in_ls_sext,
  input  logic [31:0]              in_A,
  input  logic [31:0]              in_offset,
  input  logic [31:0]              in_B,
  input  logic [4:0]               in_dest_reg,
  input  logic                     in_dest_reg_valid,
  input  logic [ROB_DEPTHLOG2-1:0] in_rob_slot,
  output logic                     rob_data_valid,
  output logic [ROB_DEPTHLOG2-1:0] rob_data_idx,
  output logic [31:0]              rob_result,
  output logic [4:0]               rob_dest_reg,
  output logic                     rob_dest_reg_valid,
  output logic                     rob_exc,
  output logic                     cache_rd,
  output logic                     cache_wr,
  output logic [31:0]              cache_addr,
  output logic [31:0]              cache_wr_data,
  output logic [3:0]               cache_wr_be,
  input  logic [31:0]              cache_data,
  input  logic                     cache_waitrequest,
  output logic [QDEPTH_LOG2:0]     occupancy
);

  localparam int                   DEPTH      = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] FULL_COUNT = (QDEPTH_LOG2 + 1)'(DEPTH);

  typedef struct packed {
    logic                     is_load;
    logic                     is_store;
    logic [1:0]               ls_op;
    logic                     sext;
    logic [31:0]              addr;
    logic [31:0]              data;
    logic [4:0]               dest_reg;
    logic                     dest_reg_valid;
    logic [ROB_DEPTHLOG2-1:0] slot;
  } entry_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  entry_t                 queue_mem [DEPTH];
  entry_t                 in_entry;
  entry_t                 head;
  entry_t                 acc;
  state_t                 state;
  logic                   acc_killed;
  logic [QDEPTH_LOG2-1:0] rd_ptr;
  logic [QDEPTH_LOG2-1:0] wr_ptr;
  logic [QDEPTH_LOG2:0]   count;
  logic                   not_empty;
  logic                   enq;
  logic                   done;
  logic                   head_access;
  logic                   head_misaligned;
  logic                   pop_idle;
  logic                   pop_next;
  logic                   pop;
  logic [31:0]            load_result;

  assign occupancy = count;
  assign in_ready  = (count != FULL_COUNT);
  assign not_empty = (count != '0);
  assign enq       = in_valid & in_ready & ~flush;
  assign head      = queue_mem[rd_ptr];

`ifdef LSQ_MISALIGN_EXC_EN
  assign head_misaligned = (head.is_load | head.is_store) &
                           ((head.ls_op == 2'd1) ? head.addr[0]
                                                 : (head.ls_op[1] & (head.addr[1:0] != 2'b00)));
`else
  assign head_misaligned = 1'b0;
`endif

  // Only ops that really touch the cache may enter ACCESS; no-ops and
  // exceptions retire straight from IDLE so one writeback per cycle is kept.
  assign head_access = (head.is_load | head.is_store) & ~head_misaligned;
  assign done        = (state == ST_ACCESS) & ~cache_waitrequest;
  assign pop_idle    = (state == ST_IDLE) & not_empty & ~flush;
  assign pop_next    = done & not_empty & ~flush & head_access;
  assign pop         = pop_idle | pop_next;

  // Pack the incoming op; the effective address is resolved here, once.
  always_comb begin
    in_entry                = '0;
    in_entry.is_load        = in_is_load;
    in_entry.is_store       = in_is_store;
    in_entry.ls_op          = in_ls_op;
    in_entry.sext           = in_ls_sext;
    in_entry.addr           = in_A + in_offset;
    in_entry.data           = in_B;
    in_entry.dest_reg       = in_dest_reg;
    in_entry.dest_reg_valid = in_dest_reg_valid;
    in_entry.slot           = in_rob_slot;
  end

  // Queue storage, written at the tail on every accepted enqueue.
  always_ff @(posedge clock) begin
    if (enq) begin
      queue_mem[wr_ptr] <= in_entry;
    end
  end

  // Head/tail pointers and occupancy; flush empties the queue.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Lane selection and extension of the returned load word.
  always_comb begin
    logic [7:0]  lb;
    logic [15:0] lh;
    case (acc.addr[1:0])
      2'd0:    lb = cache_data[7:0];
      2'd1:    lb = cache_data[15:8];
      2'd2:    lb = cache_data[23:16];
      default: lb = cache_data[31:24];
    endcase
    lh = acc.addr[1] ? cache_data[31:16] : cache_data[15:0];
    case (acc.ls_op)
      2'd0:    load_result = {{24{acc.sext & lb[7]}}, lb};
      2'd1:    load_result = {{16{acc.sext & lh[15]}}, lh};
      default: load_result = cache_data;
    endcase
  end

  // Cache strobes follow the access register; all outputs stay zero when idle.
  always_comb begin
    cache_rd      = 1'b0;
    cache_wr      = 1'b0;
    cache_addr    = '0;
    cache_wr_data = '0;
    cache_wr_be   = '0;
    if (state == ST_ACCESS) begin
      cache_addr = {acc.addr[31:2], 2'b00};
      cache_rd   = acc.is_load;
      cache_wr   = acc.is_store & ~acc.is_load;
      if (cache_wr) begin
        case (acc.ls_op)
          2'd0: begin
            cache_wr_be   = 4'b0001 << acc.addr[1:0];
            cache_wr_data = {4{acc.data[7:0]}};
          end
          2'd1: begin
            cache_wr_be   = acc.addr[1] ? 4'b1100 : 4'b0011;
            cache_wr_data = {2{acc.data[15:0]}};
          end
          default: begin
            cache_wr_be   = 4'b1111;
            cache_wr_data = acc.data;
          end
        endcase
      end
    end
  end

  // Pop/access sequencing and the one-cycle registered ROB writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= ST_IDLE;
      acc                <= '0;
      acc_killed         <= 1'b0;
      rob_data_valid     <= 1'b0;
      rob_data_idx       <= '0;
      rob_result         <= '0;
      rob_dest_reg       <= '0;
      rob_dest_reg_valid <= 1'b0;
      rob_exc            <= 1'b0;
    end else begin
      rob_data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop_idle) begin
            if (head_access) begin
              acc        <= head;
              acc_killed <= 1'b0;
              state      <= ST_ACCESS;
            end else begin
              rob_data_valid     <= 1'b1;
              rob_data_idx       <= head.slot;
              rob_result         <= '0;
              rob_dest_reg       <= head.dest_reg;
              rob_dest_reg_valid <= head.dest_reg_valid & ~head_misaligned;
              rob_exc            <= head_misaligned;
            end
          end
        end
        ST_ACCESS: begin
          if (done) begin
            // A flushed op still has to finish its bus cycle but must not retire.
            if (!acc_killed && !flush) begin
              rob_data_valid     <= 1'b1;
              rob_data_idx       <= acc.slot;
              rob_result         <= acc.is_load ? load_result : 32'd0;
              rob_dest_reg       <= acc.dest_reg;
              rob_dest_reg_valid <= acc.dest_reg_valid & acc.is_load;
              rob_exc            <= 1'b0;
            end
            if (pop_next) begin
              acc        <= head;
              acc_killed <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else if (flush) begin
            acc_killed <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ls_queue_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls_queue_unit
// Brief    : Self-checking bench for ls_queue_unit. It uses directed timing
//            scenarios plus a randomized op stream, and checks against an
//            op-level expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ls_queue_unit;

  localparam int RW = 4;
  localparam int QL = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_is_load = 1'b0;
  logic          in_is_store = 1'b0;
  logic [1:0]    in_ls_op = '0;
  logic          in_ls_sext = 1'b0;
  logic [31:0]   in_A = '0;
  logic [31:0]   in_offset = '0;
  logic [31:0]   in_B = '0;
  logic [4:0]    in_dest_reg = '0;
  logic          in_dest_reg_valid = 1'b0;
  logic [RW-1:0] in_rob_slot = '0;
  logic          in_ready;
  logic          rob_data_valid;
  logic [RW-1:0] rob_data_idx;
  logic [31:0]   rob_result;
  logic [4:0]    rob_dest_reg;
  logic          rob_dest_reg_valid;
  logic          rob_exc;
  logic          cache_rd;
  logic          cache_wr;
  logic [31:0]   cache_addr;
  logic [31:0]   cache_wr_data;
  logic [3:0]    cache_wr_be;
  logic [31:0]   cache_data;
  logic          cache_waitrequest;
  logic [QL:0]   occupancy;

  logic          rand_wait = 1'b0;
  logic          wait_ctl = 1'b0;
  logic          rnd_wait_bit = 1'b0;
  logic          use_fixed = 1'b0;
  logic [31:0]   fixed_data = '0;

  int n_checks = 0;
  int n_errors = 0;
  int wb_seen  = 0;

  typedef struct {
    bit          ld;
    bit          st;
    bit [1:0]    op;
    bit          sx;
    bit [31:0]   a;
    bit [31:0]   off;
    bit [31:0]   b;
    bit [4:0]    rd;
    bit          rdv;
    bit [RW-1:0] slot;
  } op_t;

  typedef struct {
    bit [31:0] idx;
    bit [31:0] result;
    bit [31:0] dest;
    bit        dvalid;
    bit        exc;
  } wb_t;

  typedef struct {
    bit        rd;
    bit        wr;
    bit [31:0] addr;
    bit [31:0] data;
    bit [3:0]  be;
  } acc_t;

  wb_t  exp_wb[$];
  acc_t exp_acc[$];
  wb_t  mw;
  acc_t mc;

  ls_queue_unit #(.ROB_DEPTHLOG2(RW), .QDEPTH_LOG2(QL)) dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_is_load        (in_is_load),
    .in_is_store       (in_is_store),
    .in_ls_op          (in_ls_op),
    .in_ls_sext        (in_ls_sext),
    .in_A              (in_A),
    .in_offset         (in_offset),
    .in_B              (in_B),
    .in_dest_reg       (in_dest_reg),
    .in_dest_reg_valid (in_dest_reg_valid),
    .in_rob_slot       (in_rob_slot),
    .rob_data_valid    (rob_data_valid),
    .rob_data_idx      (rob_data_idx),
    .rob_result        (rob_result),
    .rob_dest_reg      (rob_dest_reg),
    .rob_dest_reg_valid(rob_dest_reg_valid),
    .rob_exc           (rob_exc),
    .cache_rd          (cache_rd),
    .cache_wr          (cache_wr),
    .cache_addr        (cache_addr),
    .cache_wr_data     (cache_wr_data),
    .cache_wr_be       (cache_wr_be),
    .cache_data        (cache_data),
    .cache_waitrequest (cache_waitrequest),
    .occupancy         (occupancy)
  );

  always #5 clock = ~clock;

  // Backing memory: every aligned word has a fixed pseudo-random value.
  function automatic bit [31:0] mem_word(input bit [31:0] aligned);
    return (aligned ^ 32'h5A5A_1234) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic bit [31:0] data_for(input bit [31:0] aligned);
    return use_fixed ? fixed_data : mem_word(aligned);
  endfunction

  assign cache_data        = use_fixed ? fixed_data : mem_word(cache_addr);
  assign cache_waitrequest = rand_wait ? rnd_wait_bit : wait_ctl;

  always @(posedge clock) begin
    #1;
    rnd_wait_bit = ($urandom_range(0, 2) == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Lane extraction written from the byte/half/word rules directly.
  function automatic bit [31:0] extract(input bit [31:0] w, input bit [31:0] addr,
                                        input bit [1:0] op, input bit sx);
    bit [31:0] v;
    if (op == 2'd0) begin
      v = (w >> (8 * addr[1:0])) & 32'h0000_00FF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op == 2'd1) begin
      v = (w >> (addr[1] ? 16 : 0)) & 32'h0000_FFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Turn one accepted op into its expected cache access and writeback.
  task automatic record(input op_t o);
    bit [31:0] addr;
    bit [31:0] al;
    bit        mis;
    wb_t       w;
    acc_t      c;
    addr = o.a + o.off;
    al   = addr & ~32'h3;
    mis  = 1'b0;
`ifdef LSQ_MISALIGN_EXC_EN
    mis = (o.ld || o.st) && ((o.op == 2'd1 && addr[0]) || (o.op >= 2'd2 && addr[1:0] != 2'd0));
`endif
    w.idx    = 32'(o.slot);
    w.dest   = 32'(o.rd);
    w.result = 0;
    w.exc    = 1'b0;
    w.dvalid = o.rdv;
    c.rd = 1'b0; c.wr = 1'b0; c.addr = al; c.data = 0; c.be = 4'h0;
    if (!o.ld && !o.st) begin
      // no-op: retires with result 0
    end else if (mis) begin
      w.exc    = 1'b1;
      w.dvalid = 1'b0;
    end else if (o.ld) begin
      c.rd     = 1'b1;
      w.result = extract(data_for(al), addr, o.op, o.sx);
      exp_acc.push_back(c);
    end else begin
      c.wr     = 1'b1;
      w.dvalid = 1'b0;
      if (o.op == 2'd0) begin
        c.be   = 4'(1 << addr[1:0]);
        c.data = 32'(o.b[7:0]) * 32'h0101_0101;
      end else if (o.op == 2'd1) begin
        c.be   = addr[1] ? 4'hC : 4'h3;
        c.data = 32'(o.b[15:0]) * 32'h0001_0001;
      end else begin
        c.be   = 4'hF;
        c.data = o.b;
      end
      exp_acc.push_back(c);
    end
    exp_wb.push_back(w);
  endtask

  // Retirement and cache-transaction monitor.
  always @(negedge clock) begin
    if (!reset) begin
      if (rob_data_valid) begin
        wb_seen++;
        if (exp_wb.size() == 0) begin
          check("wb_unexpected", 32'(rob_data_valid), 32'd0);
        end else begin
          mw = exp_wb.pop_front();
          check("wb_idx",    32'(rob_data_idx),       mw.idx);
          check("wb_result", rob_result,              mw.result);
          check("wb_dest",   32'(rob_dest_reg),       mw.dest);
          check("wb_dvalid", 32'(rob_dest_reg_valid), 32'(mw.dvalid));
          check("wb_exc",    32'(rob_exc),            32'(mw.exc));
        end
      end
      if ((cache_rd || cache_wr) && !cache_waitrequest) begin
        if (exp_acc.size() == 0) begin
          check("acc_unexpected", {30'd0, cache_rd, cache_wr}, 32'd0);
        end else begin
          mc = exp_acc.pop_front();
          check("acc_rd",   32'(cache_rd),    32'(mc.rd));
          check("acc_wr",   32'(cache_wr),    32'(mc.wr));
          check("acc_addr", cache_addr,       mc.addr);
          check("acc_be",   32'(cache_wr_be), 32'(mc.be));
          if (mc.wr) check("acc_data", cache_wr_data, mc.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input op_t o);
    in_is_load        = o.ld;
    in_is_store       = o.st;
    in_ls_op          = o.op;
    in_ls_sext        = o.sx;
    in_A              = o.a;
    in_offset         = o.off;
    in_B              = o.b;
    in_dest_reg       = o.rd;
    in_dest_reg_valid = o.rdv;
    in_rob_slot       = o.slot;
  endtask

  // Present an op until accepted; returns just after the accepting edge.
  task automatic send(input op_t o);
    bit ok;
    drive(o);
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clock);
      ok = in_ready && !flush;
      tick();
      if (ok) begin
        in_valid = 1'b0;
        record(o);
        return;
      end
    end
    in_valid = 1'b0;
    check("send_timeout_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((exp_wb.size() != 0 || exp_acc.size() != 0) && k < limit) begin
      tick();
      k++;
    end
    check("drain_left", 32'(exp_wb.size() + exp_acc.size()), 32'd0);
    tick();
  endtask

  function automatic op_t mk(input bit ld, input bit st, input bit [1:0] op, input bit sx,
                             input bit [31:0] a, input bit [31:0] off, input bit [31:0] b,
                             input bit [4:0] rd, input bit [RW-1:0] slot);
    op_t o;
    o.ld = ld; o.st = st; o.op = op; o.sx = sx; o.a = a; o.off = off; o.b = b;
    o.rd = rd; o.rdv = 1'b1; o.slot = slot;
    return o;
  endfunction

  function automatic op_t rand_op(input int i);
    op_t o;
    int  k;
    k     = $urandom_range(0, 7);
    o.ld  = (k >= 1 && k <= 4);
    o.st  = (k >= 5);
    o.op  = 2'($urandom_range(0, 3));
    o.sx  = 1'($urandom_range(0, 1));
    o.a   = $urandom;
    o.off = 32'($urandom_range(0, 64));
    o.b   = $urandom;
    o.rd  = 5'($urandom_range(0, 31));
    o.rdv = 1'($urandom_range(0, 1));
    o.slot = RW'(i);
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid",     32'(rob_data_valid), 32'd0);
    check("rst_rd",        32'(cache_rd),       32'd0);
    check("rst_wr",        32'(cache_wr),       32'd0);
    check("rst_addr",      cache_addr,          32'd0);
    check("rst_occupancy", 32'(occupancy),      32'd0);
    check("rst_in_ready",  32'(in_ready),       32'd1);
    check("rst_exc",       32'(rob_exc),        32'd0);
    tick();

    // Word store, zero wait states
    send(mk(1'b0, 1'b1, 2'd2, 1'b0, 32'h1000, 32'd4, 32'hDEAD_BEEF, 5'd7, 4'd1));
    @(negedge clock);
    check("t1_wr_early", 32'(cache_wr), 32'd0);
    @(negedge clock);
    check("t1_wr",   32'(cache_wr),    32'd1);
    check("t1_addr", cache_addr,       32'h1004);
    check("t1_be",   32'(cache_wr_be), 32'hF);
    check("t1_data", cache_wr_data,    32'hDEAD_BEEF);
    @(negedge clock);
    check("t1_valid",  32'(rob_data_valid),     32'd1);
    check("t1_dvalid", 32'(rob_dest_reg_valid), 32'd0);
    @(negedge clock);
    check("t1_valid_pulse", 32'(rob_data_valid), 32'd0);
    tick();
    drain(20);

    // Sign-extended byte load, two wait states
    use_fixed  = 1'b1;
    fixed_data = 32'h80FF_FFFF;
    wait_ctl   = 1'b1;
    send(mk(1'b1, 1'b0, 2'd0, 1'b1, 32'h2000, 32'd3, 32'd0, 5'd9, 4'd2));
    tick();
    @(negedge clock);
    check("t2_rd_stall", 32'(cache_rd), 32'd1);
    tick();
    tick();
    wait_ctl = 1'b0;
    @(negedge clock);
    check("t2_valid_early", 32'(rob_data_valid), 32'd0);
    tick();
    @(negedge clock);
    check("t2_valid",  32'(rob_data_valid), 32'd1);
    check("t2_result", rob_result,          32'hFFFF_FF80);
    tick();
    drain(20);
    use_fixed = 1'b0;

    // Fill the queue behind a stalled access
    wait_ctl = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(mk(i[0], ~i[0], 2'd2, 1'b0, 32'h4000 + 32'(i * 16), 32'd0, 32'h1111_0000 + 32'(i), 5'(i + 1), RW'(i)));
    end
    @(negedge clock);
    check("t3_occupancy", 32'(occupancy), 32'd4);
    check("t3_in_ready",  32'(in_ready),  32'd0);
    tick();
    drive(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 32'd0, 5'd3, 4'd9));
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("t3_occupancy_hold", 32'(occupancy), 32'd4);
    tick();
    wait_ctl = 1'b0;
    drain(50);

    // Flush while an access is stalled with three ops queued
    wait_ctl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h6000 + 32'(i * 4), 32'd0, 32'd0, 5'(i + 10), RW'(i + 8)));
    end
    @(negedge clock);
    check("t4_occupancy", 32'(occupancy), 32'd3);
    tick();
    base  = wb_seen;
    flush = 1'b1;
    drive(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h7000, 32'd0, 32'd0, 5'd20, 4'd12));
    in_valid = 1'b1;
    exp_wb.delete();
    while (exp_acc.size() > 1) void'(exp_acc.pop_back());
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    check("t4_occupancy_flushed", 32'(occupancy), 32'd0);
    check("t4_inflight_rd",       32'(cache_rd),  32'd1);
    repeat (2) tick();
    wait_ctl = 1'b0;
    repeat (5) tick();
    check("t4_no_wb",          32'(wb_seen - base),  32'd0);
    check("t4_access_done",    32'(exp_acc.size()),  32'd0);
    check("t4_occupancy_end",  32'(occupancy),       32'd0);
    check("t4_idle_rd",        32'(cache_rd),        32'd0);

    // Half load at an odd address
    use_fixed  = 1'b1;
    fixed_data = 32'h1234_ABCD;
    send(mk(1'b1, 1'b0, 2'd1, 1'b0, 32'h3000, 32'd1, 32'd0, 5'd5, 4'd3));
    @(negedge clock);
    tick();
    @(negedge clock);
`ifdef LSQ_MISALIGN_EXC_EN
    check("t5_valid", 32'(rob_data_valid), 32'd1);
    check("t5_exc",   32'(rob_exc),        32'd1);
    check("t5_no_rd", 32'(cache_rd),       32'd0);
`else
    check("t5_rd",   32'(cache_rd), 32'd1);
    check("t5_addr", cache_addr,    32'h3000);
    tick();
    @(negedge clock);
    check("t5_valid",  32'(rob_data_valid), 32'd1);
    check("t5_result", rob_result,          32'h0000_ABCD);
`endif
    tick();
    drain(20);
    use_fixed = 1'b0;

    // Reset in the middle of a stalled access
    wait_ctl = 1'b1;
    send(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000, 32'd0, 32'd0, 5'd1, 4'd4));
    send(mk(1'b1, 1'b0, 2'd2, 1'b0, 32'h8004, 32'd0, 32'd0, 5'd2, 4'd5));
    @(negedge clock);
    check("t6_rd_before", 32'(cache_rd), 32'd1);
    tick();
    reset = 1'b1;
    exp_wb.delete();
    exp_acc.delete();
    tick();
    reset    = 1'b0;
    wait_ctl = 1'b0;
    @(negedge clock);
    check("t6_rd",        32'(cache_rd),       32'd0);
    check("t6_occupancy", 32'(occupancy),      32'd0);
    check("t6_valid",     32'(rob_data_valid), 32'd0);
    check("t6_in_ready",  32'(in_ready),       32'd1);
    tick();

    // Randomized op stream with random wait states
    rand_wait = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(rand_op(i));
    end
    drain(3000);
    rand_wait = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
